// File: rtl/executer_mem_arbiter_if.sv
// Request/response bus between the executers, the memory arbiter and the memory port.
// slave = arbiter view; master = executer + memory environment view.
interface executer_mem_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int WORDS     = 4
);
    logic [NUM_PORTS-1:0]                         up_req;
    logic [NUM_PORTS-1:0]                         up_write;
    logic [NUM_PORTS-1:0]                         up_stack;
    logic [NUM_PORTS-1:0]                         up_byte;
    logic [NUM_PORTS-1:0][2:0]                    up_size;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]             up_addr;
    logic [NUM_PORTS-1:0][WORDS-1:0][DATA_W-1:0]  up_wdata;
    logic [NUM_PORTS-1:0]                         up_ack;
    logic [WORDS-1:0][DATA_W-1:0]                 up_rdata;

    logic                                         dn_req;
    logic                                         dn_write;
    logic                                         dn_stack;
    logic                                         dn_byte;
    logic [2:0]                                   dn_size;
    logic [ADDR_W-1:0]                            dn_addr;
    logic [WORDS-1:0][DATA_W-1:0]                 dn_wdata;
    logic                                         dn_ack;
    logic [WORDS-1:0][DATA_W-1:0]                 dn_rdata;

    modport slave (
        input  up_req, up_write, up_stack, up_byte, up_size, up_addr, up_wdata,
        output up_ack, up_rdata,
        output dn_req, dn_write, dn_stack, dn_byte, dn_size, dn_addr, dn_wdata,
        input  dn_ack, dn_rdata
    );

    modport master (
        output up_req, up_write, up_stack, up_byte, up_size, up_addr, up_wdata,
        input  up_ack, up_rdata,
        input  dn_req, dn_write, dn_stack, dn_byte, dn_size, dn_addr, dn_wdata,
        output dn_ack, dn_rdata
    );
endinterface

// File: rtl/executer_mem_arbiter.sv
// Round-robin arbiter forwarding one of four executer memory requests at a time to memory.
// Define MEM_ARB_FIXED_PRIORITY_EN for fixed priority (executer 0 always highest).
module executer_mem_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int WORDS     = 4
) (
    input  logic                  main_clk,
    input  logic                  main_reset,
    executer_mem_arbiter_if.slave bus,
    output logic                  busy
);
    // NUM_PORTS is fixed at 4, so the pointer wraps naturally in two bits.
    localparam int PTR_W = 2;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

    state_t                       state_q, state_d;
    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]             win_q, win_d;
    logic                         write_q, write_d;
    logic                         stack_q, stack_d;
    logic                         byte_q, byte_d;
    logic [2:0]                   size_q, size_d;
    logic [ADDR_W-1:0]            addr_q, addr_d;
    logic [WORDS-1:0][DATA_W-1:0] wdata_q, wdata_d;
    logic [WORDS-1:0][DATA_W-1:0] rdata_q, rdata_d;
    logic                         dn_req_q, dn_req_d;
    logic [NUM_PORTS-1:0]         ack_q, ack_d;
    logic                         busy_q, busy_d;

    logic                         grant_vld;
    logic [PTR_W-1:0]             grant_idx;
    logic [PTR_W-1:0]             cand;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = rr_ptr_q + PTR_W'(i);
            if (!grant_vld && bus.up_req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        write_d  = write_q;
        stack_d  = stack_q;
        byte_d   = byte_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        dn_req_d = dn_req_q;
        ack_d    = '0;
        busy_d   = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    state_d  = ST_ISSUE;
                    win_d    = grant_idx;
                    write_d  = bus.up_write[grant_idx];
                    stack_d  = bus.up_stack[grant_idx];
                    byte_d   = bus.up_byte[grant_idx];
                    size_d   = bus.up_size[grant_idx];
                    addr_d   = bus.up_addr[grant_idx];
                    wdata_d  = bus.up_wdata[grant_idx];
                    dn_req_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (bus.dn_ack) begin
                    // Writes keep the previous read data visible to the executers.
                    if (!write_q) begin
                        rdata_d = bus.dn_rdata;
                    end
`ifdef MEM_ARB_FIXED_PRIORITY_EN
                    rr_ptr_d = '0;
`else
                    rr_ptr_d = win_q + PTR_W'(1);
`endif
                    ack_d[win_q] = 1'b1;
                    dn_req_d     = 1'b0;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                dn_req_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge main_clk or posedge main_reset) begin
        if (main_reset) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            write_q  <= 1'b0;
            stack_q  <= 1'b0;
            byte_q   <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            dn_req_q <= 1'b0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            write_q  <= write_d;
            stack_q  <= stack_d;
            byte_q   <= byte_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            dn_req_q <= dn_req_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.dn_req   = dn_req_q;
    assign bus.dn_write = write_q;
    assign bus.dn_stack = stack_q;
    assign bus.dn_byte  = byte_q;
    assign bus.dn_size  = size_q;
    assign bus.dn_addr  = addr_q;
    assign bus.dn_wdata = wdata_q;
    assign bus.up_ack   = ack_q;
    assign bus.up_rdata = rdata_q;
    assign busy         = busy_q;

`ifndef SYNTHESIS
    always @(posedge main_clk) begin
        if (!main_reset) begin
            assert ($onehot0(ack_q)) else $error("up_ack has more than one bit set");
            assert (!(bus.dn_ack && state_q != ST_ISSUE))
                else $warning("dn_ack outside ISSUE ignored");
        end
    end
`endif
endmodule

// File: tb/tb_executer_mem_arbiter.sv
// Randomised self-checking bench for executer_mem_arbiter against a grant-order/data model.
module tb_executer_mem_arbiter;
    logic main_clk = 1'b0;
    logic main_reset = 1'b1;
    logic busy;

    executer_mem_arbiter_if bus ();

    executer_mem_arbiter dut (
        .main_clk   (main_clk),
        .main_reset (main_reset),
        .bus        (bus),
        .busy       (busy)
    );

    always #5 main_clk = ~main_clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: pending requests, their attributes, arbitration pointer, last read data.
    bit [3:0]    pend;
    bit          p_write [4];
    bit          p_stack [4];
    bit          p_byte  [4];
    bit [2:0]    p_size  [4];
    bit [31:0]   p_addr  [4];
    bit [63:0]   p_wdata [4];
    int          ptr_m;
    logic [63:0] last_rd;

    logic [101:0] s_attr;

    function automatic logic [101:0] attr_of(input int p);
        return {p_write[p], p_stack[p], p_byte[p], p_size[p], p_addr[p], p_wdata[p]};
    endfunction

    function automatic logic [101:0] dn_attr();
        return {bus.dn_write, bus.dn_stack, bus.dn_byte, bus.dn_size, bus.dn_addr, bus.dn_wdata};
    endfunction

    function automatic int pick(input bit [3:0] req, input int ptr);
        for (int i = 0; i < 4; i++) begin
            if (req[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic int next_ptr(input int w);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
        return 0;
`else
        return (w + 1) % 4;
`endif
    endfunction

    task automatic set_port(input int p, input bit w, input bit s, input bit b,
                            input bit [2:0] sz, input bit [31:0] a, input bit [63:0] wd);
        p_write[p] = w; p_stack[p] = s; p_byte[p] = b;
        p_size[p] = sz; p_addr[p] = a; p_wdata[p] = wd;
        bus.up_write[p] = w; bus.up_stack[p] = s; bus.up_byte[p] = b;
        bus.up_size[p] = sz; bus.up_addr[p] = a; bus.up_wdata[p] = wd;
        pend[p] = 1'b1;
        bus.up_req = pend;
    endtask

    task automatic set_rand_port(input int p);
        set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(1, 4)), $urandom, {$urandom, $urandom});
    endtask

    task automatic drop_port(input int p);
        pend[p] = 1'b0;
        bus.up_req = pend;
    endtask

    task automatic do_reset();
        main_reset = 1'b1;
        pend = '0;
        bus.up_req = '0;
        bus.dn_ack = 1'b0;
        ptr_m = 0;
        last_rd = '0;
        repeat (2) @(negedge main_clk);
        main_reset = 1'b0;
        @(negedge main_clk);
    endtask

    // Acts as memory: waits for dn_req, holds ack off for 'delay' cycles, then pulses dn_ack.
    task automatic serve(input int delay, input logic [63:0] rd, output int lat, output bit stable,
                         output logic [3:0] ack_seen, output logic [63:0] rdata_seen);
        lat = -1;
        stable = 1'b1;
        ack_seen = 'x;
        rdata_seen = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(negedge main_clk);
            if (bus.dn_req) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) return;
        s_attr = dn_attr();
        for (int i = 0; i < delay; i++) begin
            @(negedge main_clk);
            if (!bus.dn_req || dn_attr() !== s_attr) stable = 1'b0;
        end
        bus.dn_ack = 1'b1;
        bus.dn_rdata = rd;
        @(negedge main_clk);
        bus.dn_ack = 1'b0;
        bus.dn_rdata = {$urandom, $urandom};
        ack_seen = bus.up_ack;
        rdata_seen = bus.up_rdata;
        if (bus.dn_req) stable = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({bus.dn_req, bus.dn_write, bus.dn_stack, bus.dn_byte, bus.dn_size, busy, bus.up_ack} !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got req=%b busy=%b ack=%b expected all 0", bus.dn_req, busy, bus.up_ack);
        end
        tests_run++;
        if (bus.up_rdata !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h expected 0", bus.up_rdata);
        end
        tests_run++;
        if (bus.dn_addr !== 32'h0 || bus.dn_wdata !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_dn_bus: got addr=%h wdata=%h expected 0", bus.dn_addr, bus.dn_wdata);
        end
        main_reset = 1'b0;
        @(negedge main_clk);
        @(negedge main_clk);
        tests_run++;
        if (busy !== 1'b0 || bus.dn_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_req: got busy=%b dn_req=%b expected 0 0", busy, bus.dn_req);
        end
    endtask

    task automatic test_single_read();
        int lat; bit stable; logic [3:0] ack; logic [63:0] rd;
        set_port(2, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_1234, {$urandom, $urandom});
        serve(3, 64'hAAAA_BBBB_CCCC_DDDD, lat, stable, ack, rd);
        drop_port(2);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL read_latency: got %0d cycles expected 1", lat);
        end
        tests_run++;
        if (s_attr !== attr_of(2) || stable !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_dn_attr: got %h stable=%b expected %h stable=1", s_attr, stable, attr_of(2));
        end
        tests_run++;
        if (ack !== 4'b0100) begin
            tests_failed++;
            $display("FAIL read_ack: got %b expected 0100", ack);
        end
        tests_run++;
        if (rd !== 64'hAAAA_BBBB_CCCC_DDDD) begin
            tests_failed++;
            $display("FAIL read_rdata: got %h expected aaaabbbbccccdddd", rd);
        end
        last_rd = 64'hAAAA_BBBB_CCCC_DDDD;
        ptr_m = next_ptr(2);
        @(negedge main_clk);
        tests_run++;
        if (bus.up_ack !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_pulse: got ack=%b busy=%b expected 0000 0", bus.up_ack, busy);
        end
    endtask

    task automatic test_all_four();
        int lat; bit stable; logic [3:0] ack; logic [63:0] rd; logic [63:0] rv;
        do_reset();
        for (int p = 0; p < 4; p++) set_port(p, 1'b0, 1'b0, 1'b0, 3'd2, ($urandom & ~32'h3) | 32'(p), {$urandom, $urandom});
        for (int k = 0; k < 4; k++) begin
            rv = {$urandom, $urandom};
            serve(1, rv, lat, stable, ack, rd);
            tests_run++;
            if (lat < 0 || s_attr !== attr_of(k) || ack !== (4'b0001 << k) || rd !== rv) begin
                tests_failed++;
                $display("FAIL all_four_grant%0d: got ack=%b addr=%h rdata=%h expected ack=%b addr=%h rdata=%h",
                         k, ack, s_attr[95:64], rd, 4'b0001 << k, p_addr[k], rv);
            end
            drop_port(k);
            last_rd = rv;
            ptr_m = next_ptr(k);
            @(negedge main_clk);
            tests_run++;
            if (bus.up_ack !== 4'b0000) begin
                tests_failed++;
                $display("FAIL all_four_pulse%0d: got %b expected 0000", k, bus.up_ack);
            end
        end
    endtask

    task automatic test_stack_write();
        int lat; bit stable; logic [3:0] ack; logic [63:0] rd;
        set_port(1, 1'b1, 1'b1, 1'b0, 3'd3, 32'h0000_FFFA, {$urandom, $urandom});
        serve(2, {$urandom, $urandom}, lat, stable, ack, rd);
        drop_port(1);
        tests_run++;
        if (s_attr !== attr_of(1) || stable !== 1'b1) begin
            tests_failed++;
            $display("FAIL stack_write_attr: got %h stable=%b expected %h", s_attr, stable, attr_of(1));
        end
        tests_run++;
        if (ack !== 4'b0010) begin
            tests_failed++;
            $display("FAIL stack_write_ack: got %b expected 0010", ack);
        end
        tests_run++;
        if (rd !== last_rd) begin
            tests_failed++;
            $display("FAIL stack_write_rdata_held: got %h expected %h", rd, last_rd);
        end
        ptr_m = next_ptr(1);
        @(negedge main_clk);
    endtask

    task automatic test_rr_priority();
        int lat; bit stable; logic [3:0] ack; logic [63:0] rd; logic [63:0] rv; int exp;
        do_reset();
        set_port(0, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_0100, {$urandom, $urandom});
        set_port(3, 1'b0, 1'b1, 1'b0, 3'd4, 32'h0000_0300, {$urandom, $urandom});
        rv = {$urandom, $urandom};
        serve(1, rv, lat, stable, ack, rd);
        drop_port(0);
        tests_run++;
        if (ack !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rr_first: got %b expected 0001", ack);
        end
        ptr_m = next_ptr(0);
        last_rd = rv;
        @(negedge main_clk);
        set_port(0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h0000_0104, {$urandom, $urandom});
        for (int k = 0; k < 2; k++) begin
            exp = pick(pend, ptr_m);
            rv = {$urandom, $urandom};
            serve(0, rv, lat, stable, ack, rd);
            tests_run++;
            if (lat < 0 || ack !== (4'b0001 << exp) || s_attr !== attr_of(exp)) begin
                tests_failed++;
                $display("FAIL rr_order%0d: got ack=%b addr=%h expected ack=%b addr=%h",
                         k, ack, s_attr[95:64], 4'b0001 << exp, p_addr[exp]);
            end
            drop_port(exp);
            ptr_m = next_ptr(exp);
            last_rd = rv;
            @(negedge main_clk);
        end
    endtask

    task automatic test_reset_mid_issue();
        int lat; bit stable; logic [3:0] ack; logic [63:0] rd; logic [63:0] rv; int exp;
        logic [3:0] ack_any;
        do_reset();
        set_port(2, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_2000, {$urandom, $urandom});
        serve(0, {$urandom, $urandom}, lat, stable, ack, rd);
        drop_port(2);
        @(negedge main_clk);
        set_port(2, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_2004, {$urandom, $urandom});
        @(negedge main_clk);
        @(negedge main_clk);
        #2;
        main_reset = 1'b1;
        #1;
        tests_run++;
        if (bus.dn_req !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_issue: got dn_req=%b busy=%b expected 0 0", bus.dn_req, busy);
        end
        tests_run++;
        if (bus.up_rdata !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_rdata: got %h expected 0", bus.up_rdata);
        end
        drop_port(2);
        ptr_m = 0;
        last_rd = '0;
        ack_any = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge main_clk);
            ack_any |= bus.up_ack;
        end
        main_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge main_clk);
            ack_any |= bus.up_ack;
        end
        tests_run++;
        if (ack_any !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_no_ack: got %b expected 0000", ack_any);
        end
        set_port(1, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_1100, {$urandom, $urandom});
        set_port(3, 1'b0, 1'b0, 1'b0, 3'd1, 32'h0000_3300, {$urandom, $urandom});
        exp = pick(pend, ptr_m);
        rv = {$urandom, $urandom};
        serve(1, rv, lat, stable, ack, rd);
        tests_run++;
        if (lat < 0 || ack !== (4'b0001 << exp) || rd !== rv) begin
            tests_failed++;
            $display("FAIL post_reset_grant: got ack=%b rdata=%h expected ack=%b rdata=%h", ack, rd, 4'b0001 << exp, rv);
        end
        drop_port(exp);
        ptr_m = next_ptr(exp);
        last_rd = rv;
        @(negedge main_clk);
        exp = pick(pend, ptr_m);
        serve(0, rv, lat, stable, ack, rd);
        drop_port(exp);
        ptr_m = next_ptr(exp);
        @(negedge main_clk);
    endtask

    task automatic test_spurious_ack();
        logic [3:0] ack_any;
        logic busy_any, req_any;
        ack_any = '0; busy_any = 1'b0; req_any = 1'b0;
        bus.dn_ack = 1'b1;
        @(negedge main_clk);
        bus.dn_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ack_any |= bus.up_ack;
            busy_any |= busy;
            req_any |= bus.dn_req;
            @(negedge main_clk);
        end
        tests_run++;
        if (ack_any !== 4'b0000 || busy_any !== 1'b0 || req_any !== 1'b0) begin
            tests_failed++;
            $display("FAIL spurious_ack: got ack=%b busy=%b dn_req=%b expected 0000 0 0", ack_any, busy_any, req_any);
        end
    endtask

    task automatic test_random();
        int lat; bit stable; logic [3:0] ack; logic [63:0] rd; logic [63:0] rv; logic [63:0] exp_rd;
        int exp; int victim;
        for (int t = 0; t < 80; t++) begin
            for (int p = 0; p < 4; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) set_rand_port(p);
            end
            if (pend == 4'b0000) set_rand_port(int'($urandom_range(0, 3)));
            exp = pick(pend, ptr_m);
            rv = {$urandom, $urandom};
            exp_rd = p_write[exp] ? last_rd : rv;
            serve(int'($urandom_range(0, 4)), rv, lat, stable, ack, rd);
            tests_run++;
            if (lat < 0 || s_attr !== attr_of(exp) || stable !== 1'b1) begin
                tests_failed++;
                $display("FAIL rand_attr%0d: got lat=%0d attr=%h stable=%b expected attr=%h", t, lat, s_attr, stable, attr_of(exp));
            end
            tests_run++;
            if (ack !== (4'b0001 << exp) || rd !== exp_rd) begin
                tests_failed++;
                $display("FAIL rand_resp%0d: got ack=%b rdata=%h expected ack=%b rdata=%h", t, ack, rd, 4'b0001 << exp, exp_rd);
            end
            last_rd = exp_rd;
            ptr_m = next_ptr(exp);
            drop_port(exp);
            if (pend != 4'b0000 && $urandom_range(0, 5) == 0) begin
                victim = int'($urandom_range(0, 3));
                if (pend[victim]) drop_port(victim);
            end
            @(negedge main_clk);
            tests_run++;
            if (bus.up_ack !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rand_pulse%0d: got %b expected 0000", t, bus.up_ack);
            end
        end
    endtask

    initial begin
        pend = '0;
        ptr_m = 0;
        last_rd = '0;
        s_attr = '0;
        bus.up_req = '0;
        bus.up_write = '0;
        bus.up_stack = '0;
        bus.up_byte = '0;
        bus.up_size = '0;
        bus.up_addr = '0;
        bus.up_wdata = '0;
        bus.dn_ack = 1'b0;
        bus.dn_rdata = '0;
        @(negedge main_clk);
        test_reset();
        test_single_read();
        test_all_four();
        test_stack_write();
        test_rr_priority();
        test_reset_mid_issue();
        test_spurious_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
